imem_arb_ctrl: RTL and testbench

IMEM_ARB_CTRL -- requirements
Module: imem_arb_ctrl

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_arb_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_imem_arb_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: default memory
// geometry, the NOP returned for out-of-range fetches, and the arbiter
// state encoding.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W_DEF = 8;

  // RISC-V canonical NOP (addi x0, x0, 0)
  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no grant issued last cycle
    ST_FETCH = 2'd1,  // fetch granted last cycle
    ST_LOAD  = 2'd2,  // loader granted last cycle
    ST_FAIR  = 2'd3   // loader budget spent, next contested cycle is fetch's
  } imem_state_e;

endpackage

// File: rtl/imem_arb_ctrl.sv
// Instruction-memory port arbiter between the CPU fetch stage and a
// program loader, in front of a single-port synchronous SRAM.
// Optional feature macro: IMEM_LOAD_EN enables the loader write port,
// its burst limiter and the FAIR state. Without it every fetch_req is
// granted and the loader port is inert.
module imem_arb_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W       = IMEM_ADDR_W_DEF,
  parameter int unsigned MAX_LD_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PCF,
  input  logic              fetch_req,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,
  input  logic              ld_req,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // True when a byte address falls inside the 2**ADDR_W word memory
  function automatic logic addr_in_range(input logic [31:0] a);
    return ~|(a >> (ADDR_W + 2));
  endfunction

  imem_state_e state_q;
  logic        rvalid_q;
  logic        nop_q;
  logic [31:0] hold_q;

  logic        fetch_gnt_s;
  logic        ld_gnt_s;
  logic        fetch_in_rng_s;
  logic        ld_in_rng_s;
  logic        mem_en_s;
  logic        mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [31:0] mem_wdata_s;
  logic [31:0] fetch_rdata_s;

  assign fetch_in_rng_s = addr_in_range(PCF);
  assign ld_in_rng_s    = addr_in_range(ld_addr);

`ifdef IMEM_LOAD_EN
  localparam int unsigned BW = $clog2(MAX_LD_BURST + 1);

  logic [BW-1:0] burst_q;
  logic          burst_sat_s;
  logic          burst_last_s;

  assign burst_sat_s  = (burst_q == BW'(MAX_LD_BURST));
  assign burst_last_s = ((burst_q + BW'(1)) == BW'(MAX_LD_BURST));

  // Loader wins unless it has used its whole budget while fetch waits
  always_comb begin
    fetch_gnt_s = 1'b0;
    ld_gnt_s    = 1'b0;
    if (rst) begin
      fetch_gnt_s = 1'b0;
      ld_gnt_s    = 1'b0;
    end else if (ld_req && !(burst_sat_s && fetch_req)) begin
      ld_gnt_s = 1'b1;
    end else if (fetch_req) begin
      fetch_gnt_s = 1'b1;
    end else begin
      fetch_gnt_s = 1'b0;
    end
  end

  // Burst budget: counts loader grants that made fetch wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_q <= {BW{1'b0}};
    end else if (fetch_gnt_s || !fetch_req) begin
      burst_q <= {BW{1'b0}};
    end else if (ld_gnt_s) begin
      burst_q <= burst_q + BW'(1);
    end else begin
      burst_q <= burst_q;
    end
  end

  // Arbiter state machine: records last grant and the fairness hand-off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_FAIR: begin
          if (fetch_gnt_s)     state_q <= ST_FETCH;
          else if (!fetch_req) state_q <= ST_IDLE;
          else                 state_q <= ST_FAIR;
        end
        default: begin
          if (fetch_gnt_s)                          state_q <= ST_FETCH;
          else if (ld_gnt_s && fetch_req && burst_last_s) state_q <= ST_FAIR;
          else if (ld_gnt_s)                        state_q <= ST_LOAD;
          else                                      state_q <= ST_IDLE;
        end
      endcase
    end
  end
`else
  logic [31:0] unused_maxb_s;
  logic        unused_s;

  assign unused_maxb_s = 32'(MAX_LD_BURST);
  assign unused_s      = ^{ld_req, unused_maxb_s};

  assign fetch_gnt_s = fetch_req && !rst;
  assign ld_gnt_s    = 1'b0;

  // Arbiter state machine: fetch-only, tracks whether fetch was granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        default: begin
          if (fetch_gnt_s) state_q <= ST_FETCH;
          else             state_q <= ST_IDLE;
        end
      endcase
    end
  end
`endif

  // Memory port steering; out-of-range accesses never enable the SRAM
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = 32'h0000_0000;
    if (fetch_gnt_s) begin
      mem_en_s   = fetch_in_rng_s;
      mem_addr_s = PCF[ADDR_W+1:2];
    end else if (ld_gnt_s) begin
      mem_en_s    = ld_in_rng_s;
      mem_we_s    = ld_in_rng_s;
      mem_addr_s  = ld_addr[ADDR_W+1:2];
      mem_wdata_s = ld_wdata;
    end else begin
      mem_en_s = 1'b0;
    end
  end

  // Returned word: SRAM data or NOP in the valid cycle, else held value
  always_comb begin
    fetch_rdata_s = hold_q;
    if (rvalid_q) begin
      fetch_rdata_s = nop_q ? IMEM_NOP : mem_rdata;
    end else begin
      fetch_rdata_s = hold_q;
    end
  end

  // One-cycle read-return pipeline; reset drops any read in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      nop_q    <= 1'b0;
      hold_q   <= 32'h0000_0000;
    end else begin
      rvalid_q <= fetch_gnt_s;
      nop_q    <= fetch_gnt_s && !fetch_in_rng_s;
      hold_q   <= fetch_rdata_s;
    end
  end

  assign fetch_gnt    = fetch_gnt_s;
  assign ld_gnt       = ld_gnt_s;
  assign mem_en       = mem_en_s;
  assign mem_we       = mem_we_s;
  assign mem_addr     = mem_addr_s;
  assign mem_wdata    = mem_wdata_s;
  assign fetch_rvalid = rvalid_q;
  assign fetch_rdata  = fetch_rdata_s;

endmodule

// File: tb/tb_imem_arb_ctrl.sv
// Bench for imem_arb_ctrl with a write-first synchronous SRAM model.
// Word i of the SRAM starts as 0xC0DE0000 + i. Loader-path tests run
// when IMEM_LOAD_EN is defined; otherwise the loader-disabled behaviour
// is exercised.
module imem_sram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:(2**AW)-1];

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
  end

  always @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

module tb_imem_arb_ctrl;
  localparam int AW = 8;

  typedef struct packed {
    logic fg;
    logic lg;
    logic en;
    logic we;
  } gnt_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] cyc;
  } rd_t;

  localparam gnt_t G_0  = 4'b0000;
  localparam gnt_t G_F  = 4'b1010;  // fetch, memory enabled
  localparam gnt_t G_FN = 4'b1000;  // fetch out of range
  localparam gnt_t G_L  = 4'b0111;  // loader write
  localparam gnt_t G_LN = 4'b0100;  // loader out of range

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   PCF = 32'h0;
  logic          fetch_req = 1'b0;
  logic          fetch_gnt;
  logic          fetch_rvalid;
  logic [31:0]   fetch_rdata;
  logic          ld_req = 1'b0;
  logic [31:0]   ld_addr = 32'h0;
  logic [31:0]   ld_wdata = 32'h0;
  logic          ld_gnt;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  gnt_t        gnt_q[$];
  rd_t         rd_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cycle_cnt = 32'd0;
  logic [31:0] last_exp  = 32'h0;

  imem_arb_ctrl #(.ADDR_W(AW), .MAX_LD_BURST(4)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .fetch_req(fetch_req),
    .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  imem_sram #(.AW(AW)) u_mem (
    .clk(clk), .en(mem_en), .we(mem_we), .addr(mem_addr),
    .wdata(mem_wdata), .rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 32'd1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // One cycle of stimulus; expected grant pattern and optional read data are queued
  task automatic step(input logic r, input logic fr, input logic [31:0] pc,
                      input logic lr, input logic [31:0] la, input logic [31:0] lw,
                      input gnt_t eg, input logic expd, input logic [31:0] ed);
    rd_t e;
    @(posedge clk);
    #1;
    rst = r; fetch_req = fr; PCF = pc; ld_req = lr; ld_addr = la; ld_wdata = lw;
    gnt_q.push_back(eg);
    if (expd) begin
      e.data = ed;
      e.cyc  = cycle_cnt + 32'd1;
      rd_q.push_back(e);
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ed);
    step(1'b0, 1'b1, pc, 1'b0, 32'h0, 32'h0, G_F, 1'b1, ed);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, G_0, 1'b0, 32'h0);
  endtask

  // Monitor: compares grants every cycle and read data whenever rvalid is up
  always @(negedge clk) begin
    gnt_t g;
    rd_t  r;
    if (gnt_q.size() > 0) begin
      g = gnt_q.pop_front();
      check32("fetch_gnt", {31'b0, fetch_gnt}, {31'b0, g.fg});
      check32("ld_gnt",    {31'b0, ld_gnt},    {31'b0, g.lg});
      check32("mem_en",    {31'b0, mem_en},    {31'b0, g.en});
      check32("mem_we",    {31'b0, mem_we},    {31'b0, g.we});
    end
    if (rst) begin
      check32("rst_rvalid", {31'b0, fetch_rvalid}, 32'h0);
      check32("rst_rdata",  fetch_rdata, 32'h0);
      last_exp = 32'h0;
    end else if (fetch_rvalid) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h expected no valid (cycle %0d)",
                 fetch_rdata, cycle_cnt);
      end else begin
        r = rd_q.pop_front();
        check32("rdata", fetch_rdata, r.data);
        check32("rvalid_cycle", cycle_cnt, r.cyc);
        last_exp = r.data;
      end
    end else begin
      check32("rdata_hold", fetch_rdata, last_exp);
    end
  end

  initial begin
    // Reset with requests pending: grants must stay low
    step(1'b1, 1'b1, 32'h8, 1'b1, 32'h10, 32'h0, G_0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h8, 1'b1, 32'h10, 32'h0, G_0, 1'b0, 32'h0);

    // First edge after release accepts the fetch
    step(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0, G_F, 1'b1, 32'hC0DE_0002);
    fetch(32'h0000_000B, 32'hC0DE_0002);   // low address bits ignored
    fetch(32'h0000_0000, 32'hC0DE_0000);
    fetch(32'h0000_03FC, 32'hC0DE_00FF);   // top word
    idle();
    idle();

    // Out-of-range fetches return NOP without touching memory
    step(1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0, 32'h0, G_FN, 1'b1, 32'h0000_0013);
    step(1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, G_FN, 1'b1, 32'h0000_0013);
    fetch(32'h0000_0004, 32'hC0DE_0001);
    idle();

`ifdef IMEM_LOAD_EN
    // Write then fetch the same word on consecutive cycles
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'hDEAD_BEEF, G_L, 1'b0, 32'h0);
    fetch(32'h10, 32'hDEAD_BEEF);

    // Contention: four loader grants then one fetch, repeated
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9)
        step(1'b0, 1'b1, 32'h4, 1'b1, 32'h80, 32'h1111_0000 + 32'(i), G_F, 1'b1, 32'hC0DE_0001);
      else
        step(1'b0, 1'b1, 32'h4, 1'b1, 32'h80, 32'h1111_0000 + 32'(i), G_L, 1'b0, 32'h0);
    end
    fetch(32'h80, 32'h1111_0008);

    // Out-of-range loader write is granted but dropped
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 32'hBAD0_BAD0, G_LN, 1'b0, 32'h0);
    fetch(32'h0, 32'hC0DE_0000);

    // Burst count clears when fetch_req drops
    step(1'b0, 1'b1, 32'h4, 1'b1, 32'hC0, 32'h2222_0000, G_L, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h4, 1'b1, 32'hC0, 32'h2222_0001, G_L, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h4, 1'b1, 32'hC0, 32'h2222_0002, G_L, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 32'h4, 1'b1, 32'hC0, 32'h2222_0003 + 32'(i), G_L, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h4, 1'b1, 32'hC0, 32'h2222_0007, G_F, 1'b1, 32'hC0DE_0001);
    idle();
`else
    // Loader disabled: fetch always wins, loader never granted, no write
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h4, 1'b1, 32'h10, 32'h5555_0000, G_F, 1'b1, 32'hC0DE_0001);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h5555_0000, G_0, 1'b0, 32'h0);
    fetch(32'h10, 32'hC0DE_0004);
    idle();
`endif

    // Reset in the cycle after a fetch grant drops the read
    step(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0, G_F, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0, G_0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, G_0, 1'b0, 32'h0);
    idle();
    idle();
    fetch(32'h8, 32'hC0DE_0002);
    idle();
    idle();

    @(posedge clk);
    #1;
    check32("rd_queue_drained", 32'(rd_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
